// File: rtl/riscy_mem_pkg.sv
// rtl/riscy_mem_pkg.sv - shared memory-access encodings for arbiter, LSU and decode
//
// Purpose: access-size codes, arbiter state enum and requester-owner enum.
// Ports: none (package).
package riscy_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane alignment helper for the memory arbiter
//
// Purpose: combinational misalignment check, store strobe/data replication,
// load lane select and sign/zero extension.
// Ports:
//   size        in  2   access size code (SZ_BYTE/SZ_HALF/SZ_WORD, 3 illegal)
//   addr_lo     in  2   byte offset within the word
//   is_unsigned in  1   zero-extend loads
//   wdata       in  32  right-aligned store data
//   rdata       in  32  raw memory word
//   misaligned  out 1   access cannot be performed
//   we_mask     out 4   byte strobes for a store
//   wdata_lane  out 32  store data replicated into every lane
//   rdata_ext   out 32  selected and extended load data
module mem_lane_align
  import riscy_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  we_mask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign byte_shift = rdata >> {addr_lo, 3'b000};
  assign half_shift = rdata >> {addr_lo[1], 4'b0000};

  always_comb begin
    misaligned = 1'b0;
    we_mask    = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (size)
      SZ_BYTE: begin
        we_mask    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~is_unsigned & byte_shift[7]}}, byte_shift[7:0]};
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        we_mask    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~is_unsigned & half_shift[15]}}, half_shift[15:0]};
      end
      SZ_WORD: begin
        misaligned = (addr_lo != 2'b00);
        we_mask    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter for the single-port memory
//
// Purpose: grants one fetch or data request at a time, sequences the memory
// access (IDLE/ISSUE/WAIT/RESP) and returns extended load data or an error.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_req/i_addr                fetch request (held until i_done)
//   i_done/i_rdata/i_err        fetch response pulse, word, misaligned flag
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata   data request
//   d_done/d_rdata/d_err        data response pulse, extended load data, error
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata    memory port (1-cycle read latency)
module mem_arbiter
  import riscy_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_e        state;
  owner_e            owner;
  owner_e            last_grant;
  owner_e            grant;
  logic [1:0]        lat_size;
  logic [1:0]        lat_addr_lo;
  logic              lat_unsigned;
  logic              lat_we;

  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_store;
  logic              idle;
  logic [1:0]        al_size;
  logic [1:0]        al_addr_lo;
  logic              al_unsigned;
  logic              misaligned;
  logic [3:0]        we_mask;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_ext;
  logic              unused_addr_hi;

  // Contested grant goes to the side that did not win last time.
  always_comb begin
    grant = OWN_I;
    if (i_req && d_req) begin
      grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      grant = OWN_D;
    end
  end

  assign req_addr  = (grant == OWN_D) ? d_addr : i_addr;
  assign req_size  = (grant == OWN_D) ? d_size : SZ_WORD;
  assign req_store = (grant == OWN_D) && d_we;
  assign unused_addr_hi = ^req_addr[ADDR_W-1:MEM_AW+2];

  // The aligner sees the incoming request while idle (error check, store lanes)
  // and the latched request afterwards (load lane select in WAIT).
  assign idle        = (state == ST_IDLE);
  assign al_size     = idle ? req_size : lat_size;
  assign al_addr_lo  = idle ? req_addr[1:0] : lat_addr_lo;
  assign al_unsigned = idle ? ((grant == OWN_D) && d_unsigned) : lat_unsigned;

  mem_lane_align u_align (
    .size        (al_size),
    .addr_lo     (al_addr_lo),
    .is_unsigned (al_unsigned),
    .wdata       (d_wdata),
    .rdata       (mem_rdata),
    .misaligned  (misaligned),
    .we_mask     (we_mask),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      owner        <= OWN_I;
      last_grant   <= OWN_D;
      lat_size     <= SZ_BYTE;
      lat_addr_lo  <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_we       <= 1'b0;
      i_done       <= 1'b0;
      i_err        <= 1'b0;
      i_rdata      <= '0;
      d_done       <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 4'b0000;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      i_done <= 1'b0;
      i_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 4'b0000;
      case (state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            owner        <= grant;
            last_grant   <= grant;
            lat_size     <= req_size;
            lat_addr_lo  <= req_addr[1:0];
            lat_unsigned <= al_unsigned;
            lat_we       <= req_store;
            if (misaligned) begin
              // Rejected without touching memory.
              state <= ST_RESP;
              if (grant == OWN_D) begin
                d_done <= 1'b1;
                d_err  <= 1'b1;
              end else begin
                i_done <= 1'b1;
                i_err  <= 1'b1;
              end
            end else begin
              state    <= ST_ISSUE;
              mem_en   <= 1'b1;
              mem_addr <= req_addr[MEM_AW+1:2];
              if (req_store) begin
                mem_we    <= we_mask;
                mem_wdata <= wdata_lane;
              end
            end
          end
        end
        ST_ISSUE: begin
          if (lat_we) begin
            state  <= ST_RESP;
            d_done <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state <= ST_RESP;
          if (owner == OWN_D) begin
            d_done  <= 1'b1;
            d_rdata <= rdata_ext;
          end else begin
            i_done  <= 1'b1;
            i_rdata <= rdata_ext;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(.ADDR_W(32), .MEM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory array driven by the DUT, plus a byte-level reference image.
  logic [31:0] mem   [0:4095];
  logic [7:0]  ref_b [0:16383];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr];
      for (int j = 0; j < 4; j++)
        if (mem_we[j]) mem[mem_addr][8*j +: 8] <= mem_wdata[8*j +: 8];
    end
  end

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic        chk;
  } exp_t;

  exp_t i_q[$];
  exp_t d_q[$];
  int   order_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_mis(input logic [1:0] sz, input int off);
    return (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input int off);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 0;
    for (int k = 0; k < n; k++) v = v | ({24'b0, ref_b[off + k]} << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic do_i(input logic [31:0] addr, input int lat);
    int off;
    int n;
    bit seen;
    exp_t e;
    off = int'(addr[13:0]);
    e.err = model_mis(2'd2, off);
    e.rdata = e.err ? 32'h0 : model_load(2'd2, 1'b1, off);
    e.chk = !e.err;
    i_q.push_back(e);
    i_addr = addr;
    i_req = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (lat >= 0 && n == 1) begin
        chk("i_mem_en", {31'b0, mem_en}, {31'b0, !e.err});
        if (!e.err) chk("i_mem_addr", {20'b0, mem_addr}, off / 4);
      end
      if (i_done) seen = 1;
    end
    if (!seen) chk("i_timeout", {31'b0, i_done}, 32'd1);
    else if (lat >= 0) chk("i_latency", n, lat);
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int lat);
    int off;
    int n;
    int nb;
    bit seen;
    exp_t e;
    logic [3:0]  mask;
    logic [31:0] rep;
    off = int'(addr[13:0]);
    nb = 1 << sz;
    e.err = model_mis(sz, off);
    e.rdata = 0;
    e.chk = !e.err && !we;
    mask = 0;
    rep = 0;
    if (!e.err) begin
      for (int k = 0; k < nb; k++) mask[(off % 4) + k] = 1'b1;
      for (int j = 0; j < 4; j++) rep[8*j +: 8] = wd[8*(j % nb) +: 8];
      if (we) for (int k = 0; k < nb; k++) ref_b[off + k] = wd[8*k +: 8];
      else e.rdata = model_load(sz, uns, off);
    end
    d_q.push_back(e);
    d_we = we; d_size = sz; d_unsigned = uns; d_addr = addr; d_wdata = wd;
    d_req = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (lat >= 0 && n == 1) begin
        chk("d_mem_en", {31'b0, mem_en}, {31'b0, !e.err});
        if (!e.err) begin
          chk("d_mem_addr", {20'b0, mem_addr}, off / 4);
          chk("d_mem_we", {28'b0, mem_we}, we ? {28'b0, mask} : 32'd0);
          if (we) chk("d_mem_wdata", mem_wdata, rep);
        end
      end
      if (d_done) seen = 1;
    end
    if (!seen) chk("d_timeout", {31'b0, d_done}, 32'd1);
    else if (lat >= 0) chk("d_latency", n, lat);
    d_req = 1'b0;
  endtask

  // Monitor: pops expectations when a done pulse appears, plus bus invariants.
  initial begin
    logic prev_en;
    exp_t e;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (i_done) begin
        chk("done_overlap", {31'b0, d_done}, 32'd0);
        if (i_q.size() == 0) chk("i_done_extra", {31'b0, i_done}, 32'd0);
        else begin
          e = i_q.pop_front();
          chk("i_err", {31'b0, i_err}, {31'b0, e.err});
          if (e.chk) chk("i_rdata", i_rdata, e.rdata);
        end
        order_q.push_back(0);
      end
      if (d_done) begin
        if (d_q.size() == 0) chk("d_done_extra", {31'b0, d_done}, 32'd0);
        else begin
          e = d_q.pop_front();
          chk("d_err", {31'b0, d_err}, {31'b0, e.err});
          if (e.chk) chk("d_rdata", d_rdata, e.rdata);
        end
        order_q.push_back(1);
      end
      if (mem_en) chk("mem_en_single", {31'b0, prev_en}, 32'd0);
      if (mem_we != 4'b0000) chk("we_without_en", {31'b0, mem_en}, 32'd1);
      prev_en = mem_en;
    end
  end

  initial begin
    rst_n = 1'b0;
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_size = 0; d_unsigned = 0; d_addr = 0; d_wdata = 0;
    for (int w = 0; w < 4096; w++) begin
      mem[w] = (w == 4) ? 32'hDEAD_BEEF : $urandom();
      for (int j = 0; j < 4; j++) ref_b[4*w + j] = mem[w][8*j +: 8];
    end
    repeat (3) @(negedge clk);
    chk("rst_i_done", {31'b0, i_done}, 32'd0);
    chk("rst_i_err", {31'b0, i_err}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_done", {31'b0, d_done}, 32'd0);
    chk("rst_d_err", {31'b0, d_err}, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed single-requester accesses with exact latency.
    do_i(32'h10, 3); @(negedge clk);
    chk("fetch_0x10", i_rdata, 32'hDEAD_BEEF);
    do_d(1, 2'd2, 0, 32'h10, 32'h80FF_0000, 2); @(negedge clk);
    do_d(0, 2'd0, 0, 32'h13, 0, 3); @(negedge clk);
    chk("lb_0x13", d_rdata, 32'hFFFF_FF80);
    do_d(0, 2'd0, 1, 32'h13, 0, 3); @(negedge clk);
    chk("lbu_0x13", d_rdata, 32'h0000_0080);
    do_d(0, 2'd1, 0, 32'h12, 0, 3); @(negedge clk);
    chk("lh_0x12", d_rdata, 32'hFFFF_80FF);
    do_d(1, 2'd1, 0, 32'h22, 32'h1234_ABCD, 2); @(negedge clk);
    do_d(1, 2'd2, 0, 32'h24, 32'h5566_7788, 2); @(negedge clk);
    do_d(0, 2'd2, 0, 32'h24, 0, 3); @(negedge clk);
    do_d(0, 2'd2, 0, 32'h06, 0, 1); @(negedge clk);
    do_d(0, 2'd3, 0, 32'h08, 0, 1); @(negedge clk);
    do_i(32'h02, 1); @(negedge clk);

    // Both requesters held from reset: grants must alternate starting with fetch.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    order_q.delete();
    fork
      begin for (int k = 0; k < 4; k++) do_i(32'h400 + 4 * k, -1); end
      begin for (int k = 0; k < 4; k++) do_d(0, 2'd2, 0, 32'h800 + 4 * k, 0, -1); end
    join
    chk("contest_count", order_q.size(), 8);
    if (order_q.size() >= 8)
      for (int k = 0; k < 8; k++) chk("contest_order", order_q[k], k % 2);
    @(negedge clk);

    // Reset while a load sits in WAIT: abandoned, no done pulse.
    d_we = 0; d_size = 2'd2; d_unsigned = 0; d_addr = 32'h840; d_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk("wrst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("wrst_mem_we", {28'b0, mem_we}, 32'd0);
    chk("wrst_mem_addr", {20'b0, mem_addr}, 32'd0);
    chk("wrst_mem_wdata", mem_wdata, 32'd0);
    chk("wrst_d_done", {31'b0, d_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    order_q.delete();
    fork
      do_i(32'h404, -1);
      do_d(0, 2'd1, 1, 32'h842, 0, -1);
    join
    chk("post_rst_count", order_q.size(), 2);
    if (order_q.size() > 0) chk("post_rst_first", order_q[0], 0);
    @(negedge clk);

    // Randomized concurrent traffic in disjoint fetch/data regions.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          do_i(($urandom() & 32'hFFFF_C000) | (32'd1024 + $urandom_range(0, 255)), -1);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          do_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom() & 32'hFFFF_C000) | (32'd2048 + $urandom_range(0, 255)),
               $urandom(), -1);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    for (int w = 512; w < 576; w++)
      chk("mem_final", mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
    chk("i_q_empty", i_q.size(), 0);
    chk("d_q_empty", d_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
